// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the hardwired control unit.
// Holds the opcode values, the ALU function encodings, the instruction class
// enumeration and the sequencer state enumeration.
package cu_pkg;

    // Width of the ALU function code that the decoder produces
    localparam int ALU_W = 4;

    // Opcodes, taken from IR[31:27]
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU function codes; ALU_NONE is driven whenever the ALU is idle
    localparam logic [ALU_W-1:0] ALU_NONE = 4'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd4;
    localparam logic [ALU_W-1:0] ALU_ROR  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_ROL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SHR  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SHRA = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SHL  = 4'd9;
    localparam logic [ALU_W-1:0] ALU_MUL  = 4'd10;
    localparam logic [ALU_W-1:0] ALU_DIV  = 4'd11;
    localparam logic [ALU_W-1:0] ALU_NEG  = 4'd12;
    localparam logic [ALU_W-1:0] ALU_NOT  = 4'd13;

    // Instruction classes; each class has its own execute sequence
    typedef enum logic [2:0] {
        CL_RTYPE,
        CL_IMM,
        CL_LONG,
        CL_UNARY,
        CL_NOP,
        CL_HALT,
        CL_ILL
    } op_class_e;

    // Sequencer states: idle, fetch/execute steps T0..T6, halted
    typedef enum logic [3:0] {
        S_IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        S_HALT
    } state_e;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode decoder.
// Maps IR[31:27] to its instruction class, the ALU function the execute
// steps must request, and a legal flag for opcodes outside the defined set.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0]       opcode,
    output op_class_e        op_class,
    output logic [ALU_W-1:0] alu,
    output logic             legal
);

    // Opcode -> class / ALU function; unknown opcodes fall to CL_ILL
    always_comb begin
        op_class = CL_ILL;
        alu      = ALU_NONE;
        case (opcode)
            OP_ADD:  begin op_class = CL_RTYPE; alu = ALU_ADD;  end
            OP_SUB:  begin op_class = CL_RTYPE; alu = ALU_SUB;  end
            OP_AND:  begin op_class = CL_RTYPE; alu = ALU_AND;  end
            OP_OR:   begin op_class = CL_RTYPE; alu = ALU_OR;   end
            OP_ROR:  begin op_class = CL_RTYPE; alu = ALU_ROR;  end
            OP_ROL:  begin op_class = CL_RTYPE; alu = ALU_ROL;  end
            OP_SHR:  begin op_class = CL_RTYPE; alu = ALU_SHR;  end
            OP_SHRA: begin op_class = CL_RTYPE; alu = ALU_SHRA; end
            OP_SHL:  begin op_class = CL_RTYPE; alu = ALU_SHL;  end
            OP_ADDI: begin op_class = CL_IMM;   alu = ALU_ADD;  end
            OP_ANDI: begin op_class = CL_IMM;   alu = ALU_AND;  end
            OP_ORI:  begin op_class = CL_IMM;   alu = ALU_OR;   end
            OP_DIV:  begin op_class = CL_LONG;  alu = ALU_DIV;  end
            OP_MUL:  begin op_class = CL_LONG;  alu = ALU_MUL;  end
            OP_NEG:  begin op_class = CL_UNARY; alu = ALU_NEG;  end
            OP_NOT:  begin op_class = CL_UNARY; alu = ALU_NOT;  end
            OP_NOP:  op_class = CL_NOP;
            OP_HALT: op_class = CL_HALT;
            default: op_class = CL_ILL;
        endcase
        legal = (op_class != CL_ILL);
    end

endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: hardwired control unit for the single-bus datapath.
// Steps through fetch (T0-T2) and the class-specific execute steps (T3-T6),
// driving Moore strobes decoded from the registered state and the opcode.
// Optional feature: define CU_MEMWAIT_EN to stretch T1 until mem_rdy, with a
// WAIT_MAX-cycle timeout that raises mem_err and halts.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         ir,
    input  logic                mem_rdy,
    input  logic                stop,
    output logic                PCout,
    output logic                IncPC,
    output logic                PCin,
    output logic                MARin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                Cout,
    output logic                HIin,
    output logic                LOin,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                ill_op,
    output logic                mem_err
);

    state_e           state_q, state_d;
    logic             ill_op_q, ill_op_d;
    logic             to_t0;
    logic [ALU_W-1:0] alu_sel;

    op_class_e        dec_class;
    logic [ALU_W-1:0] dec_alu;
    logic             dec_legal;

`ifdef CU_MEMWAIT_EN
    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic              unused_ir;
    assign unused_ir = ^ir[26:0];
`else
    // mem_rdy and the wait limit only matter when the wait feature is built
    localparam int unused_wait_max = WAIT_MAX;
    logic unused_in;
    assign unused_in = ^{ir[26:0], mem_rdy};
`endif

    cu_decode u_decode (
        .opcode   (ir[31:27]),
        .op_class (dec_class),
        .alu      (dec_alu),
        .legal    (dec_legal)
    );

    // State and sticky flags; clear drops everything to idle immediately
    always_ff @(posedge clock or negedge clear) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge.
        if (!clear) begin
            state_q    <= S_IDLE;
            ill_op_q   <= 1'b0;
`ifdef CU_MEMWAIT_EN
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ill_op_q   <= ill_op_d;
`ifdef CU_MEMWAIT_EN
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
`endif
        end
    end

    // Next-state and Moore strobe decode from registered state plus opcode
    always_comb begin
        // NOTE: every value written here gets a default first, so paths that
        // do not mention it cannot infer a latch.
        state_d  = state_q;
        ill_op_d = ill_op_q;
        to_t0    = 1'b0;
        alu_sel  = ALU_NONE;
        PCout    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        Cout     = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
`ifdef CU_MEMWAIT_EN
        mem_err_d  = mem_err_q;
        wait_cnt_d = '0;
`endif

        case (state_q)
            S_IDLE: to_t0 = 1'b1;

            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = T1;
            end

            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
`ifdef CU_MEMWAIT_EN
                if (mem_rdy) begin
                    state_d = T2;
                end else if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) begin
                    mem_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
`else
                state_d = T2;
`endif
            end

            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end

            T3: begin
                if (!dec_legal) begin
                    ill_op_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    case (dec_class)
                        CL_RTYPE, CL_IMM: begin
                            Grb     = 1'b1;
                            Rout    = 1'b1;
                            Yin     = 1'b1;
                            state_d = T4;
                        end
                        CL_UNARY: begin
                            Grb     = 1'b1;
                            Rout    = 1'b1;
                            alu_sel = dec_alu;
                            Zin     = 1'b1;
                            state_d = T4;
                        end
                        CL_LONG: begin
                            Gra     = 1'b1;
                            Rout    = 1'b1;
                            Yin     = 1'b1;
                            state_d = T4;
                        end
                        CL_NOP:  to_t0   = 1'b1;
                        default: state_d = S_HALT;
                    endcase
                end
            end

            T4: begin
                case (dec_class)
                    CL_RTYPE: begin
                        Grc     = 1'b1;
                        Rout    = 1'b1;
                        alu_sel = dec_alu;
                        Zin     = 1'b1;
                        state_d = T5;
                    end
                    CL_IMM: begin
                        Cout    = 1'b1;
                        alu_sel = dec_alu;
                        Zin     = 1'b1;
                        state_d = T5;
                    end
                    CL_LONG: begin
                        Grb     = 1'b1;
                        Rout    = 1'b1;
                        alu_sel = dec_alu;
                        Zin     = 1'b1;
                        state_d = T5;
                    end
                    CL_UNARY: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                        to_t0   = 1'b1;
                    end
                    default: to_t0 = 1'b1;
                endcase
            end

            T5: begin
                case (dec_class)
                    CL_RTYPE, CL_IMM: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                        to_t0   = 1'b1;
                    end
                    CL_LONG: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                        state_d = T6;
                    end
                    default: to_t0 = 1'b1;
                endcase
            end

            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                to_t0    = 1'b1;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_IDLE;
        endcase

        // A pending stop diverts the return to T0 into the halt state
        if (to_t0) begin
            state_d = stop ? S_HALT : T0;
        end

        run = (state_q != S_IDLE) && (state_q != S_HALT);
    end

    assign alu_op = ALU_OP_W'(alu_sel);
    assign ill_op = ill_op_q;
`ifdef CU_MEMWAIT_EN
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: directed self-checking bench for cu_sequencer.
// Expected output snapshots are queued as stimulus is driven and popped and
// compared one per clock, sampled 1 time unit after the rising edge.
module tb_cu_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        mem_rdy;
    logic        stop;
    logic PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin;
    logic Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout, Cout, HIin, LOin;
    logic [3:0]  alu_op;
    logic        run, ill_op, mem_err;

    // Strobe bit positions in the packed observation vector
    localparam logic [19:0] S_PCOUT  = 20'h80000;
    localparam logic [19:0] S_INCPC  = 20'h40000;
    localparam logic [19:0] S_PCIN   = 20'h20000;
    localparam logic [19:0] S_MARIN  = 20'h10000;
    localparam logic [19:0] S_READ   = 20'h08000;
    localparam logic [19:0] S_MDRIN  = 20'h04000;
    localparam logic [19:0] S_MDROUT = 20'h02000;
    localparam logic [19:0] S_IRIN   = 20'h01000;
    localparam logic [19:0] S_YIN    = 20'h00800;
    localparam logic [19:0] S_ZIN    = 20'h00400;
    localparam logic [19:0] S_ZLO    = 20'h00200;
    localparam logic [19:0] S_ZHI    = 20'h00100;
    localparam logic [19:0] S_GRA    = 20'h00080;
    localparam logic [19:0] S_GRB    = 20'h00040;
    localparam logic [19:0] S_GRC    = 20'h00020;
    localparam logic [19:0] S_RIN    = 20'h00010;
    localparam logic [19:0] S_ROUT   = 20'h00008;
    localparam logic [19:0] S_COUT   = 20'h00004;
    localparam logic [19:0] S_HIIN   = 20'h00002;
    localparam logic [19:0] S_LOIN   = 20'h00001;
    localparam logic [19:0] NONE     = 20'h00000;

    localparam logic [19:0] F0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
    localparam logic [19:0] F1 = S_ZLO | S_PCIN | S_READ | S_MDRIN;
    localparam logic [19:0] F2 = S_MDROUT | S_IRIN;

    localparam logic [3:0] A_NONE = 4'd0;
    localparam logic [3:0] A_ADD  = 4'd1;
    localparam logic [3:0] A_AND  = 4'd3;
    localparam logic [3:0] A_MUL  = 4'd10;
    localparam logic [3:0] A_NOT  = 4'd13;

    typedef struct {
        string       tag;
        logic [19:0] s;
        logic [3:0]  a;
        logic        r;
        logic        il;
        logic        me;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [19:0] strobes;
    assign strobes = {PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                      Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout, Cout, HIin, LOin};

    cu_sequencer #(.ALU_OP_W(4), .WAIT_MAX(15)) dut (
        .clock    (clock),
        .clear    (clear),
        .ir       (ir),
        .mem_rdy  (mem_rdy),
        .stop     (stop),
        .PCout    (PCout),
        .IncPC    (IncPC),
        .PCin     (PCin),
        .MARin    (MARin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .Rin      (Rin),
        .Rout     (Rout),
        .Cout     (Cout),
        .HIin     (HIin),
        .LOin     (LOin),
        .alu_op   (alu_op),
        .run      (run),
        .ill_op   (ill_op),
        .mem_err  (mem_err)
    );

    always #5 clock = ~clock;

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic push_exp(input string tag, input logic [19:0] s, input logic [3:0] a,
                            input logic r, input logic il, input logic me);
        exp_t e;
        e.tag = tag; e.s = s; e.a = a; e.r = r; e.il = il; e.me = me;
        exp_q.push_back(e);
    endtask

    task automatic compare_head();
        exp_t        e;
        logic [26:0] obs, ex;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed=output expected=queued entry");
            return;
        end
        e   = exp_q.pop_front();
        obs = {strobes, alu_op, run, ill_op, mem_err};
        ex  = {e.s, e.a, e.r, e.il, e.me};
        assert (obs === ex) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, ex);
        end
    endtask

    // Check outputs now, without a clock edge
    task automatic now_check(input string tag, input logic [19:0] s, input logic [3:0] a,
                             input logic r, input logic il, input logic me);
        push_exp(tag, s, a, r, il, me);
        compare_head();
    endtask

    // Advance one clock, then check
    task automatic clk_check(input string tag, input logic [19:0] s, input logic [3:0] a,
                             input logic r, input logic il, input logic me);
        push_exp(tag, s, a, r, il, me);
        @(posedge clock);
        #1;
        compare_head();
    endtask

    // T1 and T2 of a fetch, called while sitting in T0
    task automatic fetch_rest();
        clk_check("T1", F1, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("T2", F2, A_NONE, 1'b1, 1'b0, 1'b0);
    endtask

    // Pulse clear across one edge, release, and land in T0
    task automatic do_reset();
        clear = 1'b0;
        #1;
        now_check("reset_async", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        clk_check("reset_held", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        now_check("idle", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        clk_check("T0_after_idle", F0, A_NONE, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        clear   = 1'b0;
        ir      = 32'h0;
        mem_rdy = 1'b1;
        stop    = 1'b0;
        #3;
        now_check("reset_state", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        now_check("reset_held", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        now_check("idle", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        clk_check("T0_first", F0, A_NONE, 1'b1, 1'b0, 1'b0);

        // and R1,R2,R3: 6-cycle R-type
        ir = 32'h28918000;
        fetch_rest();
        clk_check("and_T3", S_GRB | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("and_T4", S_GRC | S_ROUT | S_ZIN, A_AND, 1'b1, 1'b0, 1'b0);
        clk_check("and_T5", S_ZLO | S_GRA | S_RIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("and_T0", F0, A_NONE, 1'b1, 1'b0, 1'b0);

        // mul: 7-cycle long sequence
        ir = 32'h80000000;
        fetch_rest();
        clk_check("mul_T3", S_GRA | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("mul_T4", S_GRB | S_ROUT | S_ZIN, A_MUL, 1'b1, 1'b0, 1'b0);
        clk_check("mul_T5", S_ZLO | S_LOIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("mul_T6", S_ZHI | S_HIIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("mul_T0", F0, A_NONE, 1'b1, 1'b0, 1'b0);

        // not: 5-cycle unary
        ir = 32'h90000000;
        fetch_rest();
        clk_check("not_T3", S_GRB | S_ROUT | S_ZIN, A_NOT, 1'b1, 1'b0, 1'b0);
        clk_check("not_T4", S_ZLO | S_GRA | S_RIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("not_T0", F0, A_NONE, 1'b1, 1'b0, 1'b0);

        // addi: immediate uses Cout in T4
        ir = 32'h60000000;
        fetch_rest();
        clk_check("addi_T3", S_GRB | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("addi_T4", S_COUT | S_ZIN, A_ADD, 1'b1, 1'b0, 1'b0);
        clk_check("addi_T5", S_ZLO | S_GRA | S_RIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("addi_T0", F0, A_NONE, 1'b1, 1'b0, 1'b0);

        // nop: silent T3, back to T0
        ir = 32'hD0000000;
`ifdef CU_MEMWAIT_EN
        // T1 stretched: mem_rdy low for 3 stalled cycles -> 4 cycles of T1
        clk_check("wait_T1_0", F1, A_NONE, 1'b1, 1'b0, 1'b0);
        mem_rdy = 1'b0;
        clk_check("wait_T1_1", F1, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("wait_T1_2", F1, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("wait_T1_3", F1, A_NONE, 1'b1, 1'b0, 1'b0);
        mem_rdy = 1'b1;
        clk_check("wait_T2", F2, A_NONE, 1'b1, 1'b0, 1'b0);
`else
        // mem_rdy is ignored: T1 is a single cycle even with mem_rdy low
        mem_rdy = 1'b0;
        fetch_rest();
        mem_rdy = 1'b1;
`endif
        clk_check("nop_T3", NONE, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("nop_T0", F0, A_NONE, 1'b1, 1'b0, 1'b0);

        // add with stop raised in T3: completes, then halts with no T0
        ir = 32'h18000000;
        fetch_rest();
        clk_check("add_T3", S_GRB | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        clk_check("add_T4", S_GRC | S_ROUT | S_ZIN, A_ADD, 1'b1, 1'b0, 1'b0);
        clk_check("add_T5", S_ZLO | S_GRA | S_RIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("stop_halt", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        clk_check("halt_sticky", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        do_reset();

        // clear pulsed low during T4 of an and
        ir = 32'h28918000;
        fetch_rest();
        clk_check("and2_T3", S_GRB | S_ROUT | S_YIN, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("and2_T4", S_GRC | S_ROUT | S_ZIN, A_AND, 1'b1, 1'b0, 1'b0);
        #2;
        do_reset();

        // halt opcode
        ir = 32'hD8000000;
        fetch_rest();
        clk_check("halt_T3", NONE, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("halt_state", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        clk_check("halt_stays", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        do_reset();

        // illegal opcode: sticky ill_op, halted until clear
        ir = 32'hF8000000;
        fetch_rest();
        clk_check("ill_T3", NONE, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("ill_halt", NONE, A_NONE, 1'b0, 1'b1, 1'b0);
        ir = 32'h18000000;
        clk_check("ill_sticky1", NONE, A_NONE, 1'b0, 1'b1, 1'b0);
        clk_check("ill_sticky2", NONE, A_NONE, 1'b0, 1'b1, 1'b0);
        do_reset();

`ifdef CU_MEMWAIT_EN
        // mem_rdy never arrives: 15 cycles of T1, then mem_err and halt
        clk_check("to_T1_0", F1, A_NONE, 1'b1, 1'b0, 1'b0);
        mem_rdy = 1'b0;
        for (int i = 1; i < 15; i++) begin
            clk_check($sformatf("to_T1_%0d", i), F1, A_NONE, 1'b1, 1'b0, 1'b0);
        end
        clk_check("memerr_halt", NONE, A_NONE, 1'b0, 1'b0, 1'b1);
        clk_check("memerr_sticky", NONE, A_NONE, 1'b0, 1'b0, 1'b1);
        mem_rdy = 1'b1;
        do_reset();
`endif

        // stop already high on the way into T0 from a finished instruction
        ir = 32'hD0000000;
        fetch_rest();
        stop = 1'b1;
        clk_check("nop2_T3", NONE, A_NONE, 1'b1, 1'b0, 1'b0);
        clk_check("nop2_halt", NONE, A_NONE, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
